// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider.
//   DIV_W      default divisor/remainder width (dividend/quotient are 2*DIV_W)
//   ST_*       FSM state encodings
//   cnt_width  width of the iteration counter for a given divisor width
package seq_divider_pkg;

    localparam int DIV_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // One spare bit over $clog2(2w) so the counter can hold the value 2w.
    function automatic int cnt_width(input int w);
        return $clog2(2 * w) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: compare-and-subtract of the partial remainder
// against the divisor.
//   pr_i       W+1-bit partial remainder (previous remainder shifted left,
//              next dividend bit appended)
//   divisor_i  W-bit divisor
//   rem_o      next partial remainder, always < divisor, so W bits suffice
//   q_o        quotient bit produced by this step
module seq_divider_div_step #(
    parameter int W = 16
) (
    input  logic [W:0]   pr_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    // Subtraction as pr + ~{0,divisor} + 1 on a ripple-carry chain. The carry
    // out of the top bit is set exactly when pr >= divisor, which is the
    // quotient bit. The top sum bit is never needed: when the subtraction is
    // kept, the result is below the divisor and fits in W bits.
    logic [W:0]   b_inv;
    logic [W+1:0] carry;
    logic [W-1:0] diff;

    assign b_inv = ~{1'b0, divisor_i};

    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first, so no path leaves it unassigned and no latch forms.
        carry    = '0;
        diff     = '0;
        carry[0] = 1'b1;
        for (int i = 0; i <= W; i++) begin
            if (i < W) begin
                diff[i] = pr_i[i] ^ b_inv[i] ^ carry[i];
            end
            carry[i+1] = (pr_i[i] & b_inv[i]) | (carry[i] & (pr_i[i] ^ b_inv[i]));
        end
    end

    assign q_o   = carry[W+1];
    assign rem_o = q_o ? diff : pr_i[W-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per clock.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   dividend   2W-bit numerator, captured on accept
//   divisor    W-bit denominator, captured on accept
//   busy       high from the cycle after accept until done (inclusive)
//   done       one-cycle pulse, results valid from this cycle
//   quotient   2W-bit result, held until the next completed operation
//   remainder  W-bit result, held until the next completed operation
//   div_zero   divisor was zero; quotient all ones, remainder = dividend[W-1:0]
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_zero
);

    localparam int                CNT_W     = cnt_width(W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2 * W - 1);

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [2*W-1:0]   dvd_q,       dvd_d;       // dividend, shifted out MSB first
    logic [W-1:0]     dsr_q,       dsr_d;       // captured divisor
    logic [W-1:0]     rem_q,       rem_d;       // working partial remainder
    logic [2*W-1:0]   quo_q,       quo_d;       // quotient bits shifted in LSB
    logic [2*W-1:0]   quotient_q,  quotient_d;
    logic [W-1:0]     remainder_q, remainder_d;
    logic             div_zero_q,  div_zero_d;

    logic [W-1:0]     step_rem;
    logic             step_q;
    logic [2*W-1:0]   quo_next;

    seq_divider_div_step #(
        .W (W)
    ) u_div_step (
        .pr_i      ({rem_q, dvd_q[2*W-1]}),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    assign quo_next = {quo_q[2*W-2:0], step_q};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dsr_d   = divisor;
                    rem_d   = '0;
                    quo_d   = '0;
                    count_d = '0;
                    if (divisor == '0) begin
                        // No iterations: publish the defined div-by-zero result
                        // directly and go straight to the done cycle.
                        state_d     = ST_FIN;
                        quotient_d  = '1;
                        remainder_d = dividend[W-1:0];
                        div_zero_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                dvd_d   = dvd_q << 1;
                rem_d   = step_rem;
                quo_d   = quo_next;
                count_d = count_q + CNT_W'(1);
                // Results are published only with the final step so partial
                // quotients never appear on the outputs.
                if (count_q == LAST_STEP) begin
                    state_d     = ST_FIN;
                    quotient_d  = quo_next;
                    remainder_d = step_rem;
                    div_zero_d  = 1'b0;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            state_q     <= state_d;
            count_q     <= count_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = (state_q == ST_RUN) || (state_q == ST_FIN);
    assign done      = (state_q == ST_FIN);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 16;
    localparam int NORMAL_LAT = 2 * W + 1;
    localparam int TIMEOUT = 200;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] quotient;
    logic [W-1:0]   remainder;
    logic           div_zero;

    int tests_run = 0;
    int tests_failed = 0;

    seq_divider #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the operands.
    task automatic model(input logic [2*W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] q, output logic [W-1:0] r,
                         output logic dz);
        if (b == 0) begin
            q  = {(2*W){1'b1}};
            r  = a[W-1:0];
            dz = 1'b1;
        end else begin
            q  = a / {{W{1'b0}}, b};
            r  = W'(a % {{W{1'b0}}, b});
            dz = 1'b0;
        end
    endtask

    // Issue one operation from IDLE and wait for done. Operands are scrambled
    // right after accept to show they are not re-sampled. lat counts cycles
    // from the accept edge to the cycle where done is seen.
    task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic busy_first, output bit timed_out);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start      = 1'b0;
        dividend   = $urandom;
        divisor    = W'($urandom);
        busy_first = busy;
        lat        = 1;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        timed_out = !done;
    endtask

    // Run one operation and compare everything against the model.
    task automatic check_op(input string name, input logic [2*W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] exp_q;
        logic [W-1:0]   exp_r;
        logic           exp_dz;
        int             lat;
        int             exp_lat;
        logic           bf;
        bit             to;
        model(a, b, exp_q, exp_r, exp_dz);
        exp_lat = (b == 0) ? 1 : NORMAL_LAT;
        run_op(a, b, lat, bf, to);
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL %s timeout: done not seen within %0d cycles", name, TIMEOUT);
            return;
        end
        if (lat !== exp_lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        tests_run++;
        if (bf !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s busy after accept: got %b expected 1", name, bf);
        end
        tests_run++;
        if (quotient !== exp_q || remainder !== exp_r || div_zero !== exp_dz) begin
            tests_failed++;
            $display("FAIL %s result %h/%h: got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                     name, a, b, quotient, remainder, div_zero, exp_q, exp_r, exp_dz);
        end
        if (b != 0) begin
            tests_run++;
            if ((64'(quotient) * 64'(b) + 64'(remainder)) !== 64'(a) || remainder >= b) begin
                tests_failed++;
                $display("FAIL %s identity %h/%h: q=%h r=%h does not satisfy q*b+r==a, r<b",
                         name, a, b, quotient, remainder);
            end
        end
        // done must be a single-cycle pulse.
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s after done: got done=%b busy=%b expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset outputs: got busy=%b done=%b q=%h r=%h dz=%b expected all 0",
                     busy, done, quotient, remainder, div_zero);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle after reset: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        check_op("dir_100000_7", 32'd100000, 16'd7);
        check_op("dir_max_max", 32'hFFFF_FFFF, 16'hFFFF);
        check_op("dir_5_9", 32'd5, 16'd9);
        check_op("dir_0_3", 32'd0, 16'd3);
        check_op("dir_max_1", 32'hFFFF_FFFF, 16'd1);
    endtask

    task automatic test_div_zero();
        check_op("divzero", 32'h1234_5678, 16'd0);
        // A normal operation afterwards must clear div_zero.
        check_op("after_divzero", 32'd1000, 16'd10);
    endtask

    task automatic test_start_ignored();
        logic [2*W-1:0] prev_q;
        logic [W-1:0]   prev_r;
        int             lat;
        prev_q = quotient;
        prev_r = remainder;
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd100000;
        divisor  = 16'd7;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        repeat (4) begin
            @(negedge clk);
            lat++;
        end
        // Re-request with different operands while running.
        start    = 1'b1;
        dividend = 32'd1234;
        divisor  = 16'd5;
        repeat (3) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        tests_run++;
        if (quotient !== prev_q || remainder !== prev_r || done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold during run: got q=%h r=%h done=%b busy=%b expected q=%h r=%h done=0 busy=1",
                     quotient, remainder, done, busy, prev_q, prev_r);
        end
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        // Keep start high through the done cycle: it must be ignored in FIN.
        start = 1'b1;
        tests_run++;
        if (lat !== NORMAL_LAT || quotient !== 32'd14285 || remainder !== 16'd5) begin
            tests_failed++;
            $display("FAIL start ignored: got lat=%0d q=%0d r=%0d expected lat=%0d q=14285 r=5",
                     lat, quotient, remainder, NORMAL_LAT);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL start in done cycle accepted: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'hDEAD_BEEF;
        divisor  = 16'd77;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset mid-op: got busy=%b done=%b q=%h r=%h dz=%b expected all 0",
                     busy, done, quotient, remainder, div_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_op("fresh_400_20", 32'd400, 16'd20);
    endtask

    task automatic test_random();
        logic [2*W-1:0] a;
        logic [W-1:0]   b;
        logic [W-1:0]   m;
        for (int i = 0; i < 40; i++) begin
            case (i % 4)
                0: begin
                    // Multiplier product, divided by one of its factors.
                    m = W'($urandom);
                    b = W'($urandom_range(1, 65535));
                    a = 32'(m) * 32'(b);
                end
                1: begin
                    // Product plus an offset below the divisor.
                    b = W'($urandom_range(1, 65535));
                    m = W'($urandom);
                    a = 32'(m) * 32'(b) + 32'($urandom_range(0, int'(b) - 1));
                end
                2: begin
                    a = $urandom;
                    b = W'($urandom_range(1, 15));
                end
                default: begin
                    a = $urandom;
                    b = W'($urandom_range(1, 65535));
                end
            endcase
            check_op($sformatf("rand%0d", i), a, b);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] exp_q;
        logic [W-1:0]   exp_r;
        logic           exp_dz;
        int             lat;
        logic           bf;
        bit             to;
        // Start again in the first IDLE cycle right after each done.
        for (int i = 0; i < 6; i++) begin
            logic [2*W-1:0] a;
            logic [W-1:0]   b;
            a = $urandom;
            b = (i == 3) ? 16'd0 : W'($urandom_range(1, 65535));
            model(a, b, exp_q, exp_r, exp_dz);
            run_op(a, b, lat, bf, to);
            tests_run++;
            if (to || lat !== ((b == 0) ? 1 : NORMAL_LAT) || quotient !== exp_q ||
                remainder !== exp_r || div_zero !== exp_dz) begin
                tests_failed++;
                $display("FAIL b2b%0d %h/%h: got lat=%0d q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                         i, a, b, lat, quotient, remainder, div_zero, exp_q, exp_r, exp_dz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
